add_seq_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit unsigned sum by time-multiplexing one CHUNK-bit adder slice over WIDTH/CHUNK cycles, LSB chunk first.
- Carry ripples between cycles through a carry register.
- Area-reduced alternative to the flat wide adders (add256 to add1024 class) where latency is acceptable; sits between a requesting engine and its result consumer.
- Uses a start/busy/done handshake.

---
 rtl/add_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl
//   Computes a WIDTH-bit unsigned sum with one CHUNK-bit adder slice. The
//   slice is reused over NCHUNK = WIDTH/CHUNK cycles, starting with the LSB
//   chunk. The carry passes from one cycle to the next through a carry
//   register. The block uses a start/busy/done handshake.
//
//   Optional build macro: ADD_SEQ_CARRYIN_EN
//     defined   - adds input cin. It is captured on an accepted start and
//                 used as the initial carry.
//     undefined - the initial carry is 0.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   start  request; accepted only while busy=0
//   abus   operand A, captured on an accepted start
//   bbus   operand B, captured on an accepted start
//   cin    initial carry (ADD_SEQ_CARRYIN_EN builds only)
//   busy   high from the cycle after accept through the done cycle
//   done   one-cycle pulse; out/cout are valid in this cycle
//   out    sum mod 2^WIDTH; held from done until the next accept
//   cout   carry out of bit WIDTH-1; held like out
module add_seq_ctrl #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] abus,
  input  logic [WIDTH-1:0] bbus,
`ifdef ADD_SEQ_CARRYIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]              a_reg;
  logic [WIDTH-1:0]              b_reg;
  logic                          carry;
  logic [NCHUNK-1:0]             sel;
  logic [NCHUNK-1:0][CHUNK-1:0]  res;
  logic [CHUNK:0]                slice;
  logic                          init_carry;

`ifdef ADD_SEQ_CARRYIN_EN
  assign init_carry = cin;
`else
  assign init_carry = 1'b0;
`endif

  // The operand registers shift right one chunk per RUN cycle, so the
  // active chunk is always in the low CHUNK bits. The chunk index is held
  // one-hot in sel (bit k means chunk k). This keeps every part-select
  // constant.
  assign slice = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
               + (CHUNK+1)'(carry);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)           state_n = RUN;
      RUN:     if (sel[NCHUNK-1])   state_n = DONE;
      DONE:                         state_n = IDLE;
      default:                      state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sel   <= NCHUNK'(1);
      res   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= abus;
            b_reg <= bbus;
            carry <= init_carry;
            sel   <= NCHUNK'(1);
            res   <= '0;
            cout  <= 1'b0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> CHUNK;
          b_reg <= b_reg >> CHUNK;
          carry <= slice[CHUNK];
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (sel[k]) res[k] <= slice[CHUNK-1:0];
          end
          if (sel[NCHUNK-1]) cout <= slice[CHUNK];
          sel <= sel << 1;
        end
        default: ;
      endcase
    end
  end

  assign out  = res;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_add_seq_ctrl.sv
module tb_add_seq_ctrl;

  localparam int W   = 64;
  localparam int C   = 16;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] abus, bbus;
  logic         cin_v;
  logic         busy, done, cout;
  logic [W-1:0] out;

  logic         start16;
  logic [15:0]  a16, b16, out16;
  logic         busy16, done16, cout16;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  add_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .start(start), .abus(abus), .bbus(bbus),
`ifdef ADD_SEQ_CARRYIN_EN
    .cin(cin_v),
`endif
    .busy(busy), .done(done), .out(out), .cout(cout)
  );

  add_seq_ctrl #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .abus(a16), .bbus(b16),
`ifdef ADD_SEQ_CARRYIN_EN
    .cin(1'b0),
`endif
    .busy(busy16), .done(done16), .out(out16), .cout(cout16)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] eo;
    logic         eco;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input logic [W:0] got, input logic [W:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Call this at a negedge in an IDLE cycle. It returns at the negedge of
  // the IDLE cycle that follows done.
  task automatic run_check(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           input logic [W-1:0] eo, input logic eco, input bit rnd);
    int lat;
    int bcnt;
    logic [W-1:0] o;
    logic c;
    abus = a; bbus = b; cin_v = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcnt++;
      if (rnd) begin
        abus = {$urandom(), $urandom()};
        bbus = {$urandom(), $urandom()};
        cin_v = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    if (busy === 1'b1) bcnt++;
    o = out;
    c = cout;
    check("out", {1'b0, o}, {1'b0, eo});
    check("cout", {{W{1'b0}}, c}, {{W{1'b0}}, eco});
    check("latency", (W+1)'(lat), (W+1)'(NCH + 1));
    if (!rnd) check("busy_cycles", (W+1)'(bcnt), (W+1)'(NCH + 1));
    @(negedge clk);
    check("done_pulse", {{W{1'b0}}, done}, '0);
    if (!rnd) begin
      check("idle_busy", {{W{1'b0}}, busy}, '0);
      check("out_hold", {1'b0, out}, {1'b0, eo});
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   ref_sum;
    logic [W-1:0] got;
    int           ndone;
    int           lat;

    vt[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
    vt[2] = '{64'h5, 64'h7, 64'hC, 1'b0};
    vt[3] = '{64'h0, 64'h0, 64'h0, 1'b0};
    vt[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1};
    vt[6] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 64'h0001_0000_0001_0000, 1'b0};
    vt[7] = '{64'hFFFF_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 64'h0, 1'b1};

    reset = 1'b1; start = 1'b0; start16 = 1'b0;
    abus = '0; bbus = '0; cin_v = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {{W{1'b0}}, busy}, '0);
    check("rst_done", {{W{1'b0}}, done}, '0);
    check("rst_out", {1'b0, out}, '0);
    check("rst_cout", {{W{1'b0}}, cout}, '0);
    check("rst_busy16", {{W{1'b0}}, busy16}, '0);
    reset = 1'b0;
    @(negedge clk);

    // Each vector starts in the cycle right after the previous done, so
    // the table also covers back-to-back issue.
    for (int i = 0; i < 8; i++)
      run_check(vt[i].a, vt[i].b, 1'b0, vt[i].eo, vt[i].eco, 1'b0);

`ifdef ADD_SEQ_CARRYIN_EN
    run_check(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
    run_check(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
`endif

    // Start while busy: start is pulsed in cycle 2 and in the done cycle
    // (5). Both pulses must be ignored.
    abus = 64'd5; bbus = 64'd7; cin_v = 1'b0; start = 1'b1;
    @(negedge clk);
    ndone = 0;
    got = '0;
    for (int n = 1; n <= 8; n++) begin
      start = (n == 2 || n == 5);
      if (start) begin abus = 64'd100; bbus = 64'd100; end
      if (done === 1'b1) begin ndone++; got = out; end
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_start_ndone", (W+1)'(ndone), (W+1)'(1));
    check("busy_start_out", {1'b0, got}, (W+1)'(12));
    check("busy_start_idle", {{W{1'b0}}, busy}, '0);

    // Reset in the middle of an operation
    abus = 64'h1234; bbus = 64'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {{W{1'b0}}, busy}, '0);
    check("abort_done", {{W{1'b0}}, done}, '0);
    check("abort_out", {1'b0, out}, '0);
    check("abort_cout", {{W{1'b0}}, cout}, '0);
    ndone = 0;
    for (int n = 0; n < 8; n++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", (W+1)'(ndone), '0);
    run_check(64'h1234, 64'h1, 1'b0, 64'h1235, 1'b0, 1'b0);

    // Degenerate case, NCHUNK == 1
    a16 = 16'h8000; b16 = 16'h8000; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    while (done16 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("deg_latency", (W+1)'(lat), (W+1)'(2));
    check("deg_out", (W+1)'(out16), '0);
    check("deg_cout", {{W{1'b0}}, cout16}, (W+1)'(1));
    @(negedge clk);

    // Random back-to-back regression; the operand inputs are scrambled
    // while busy.
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
`ifdef ADD_SEQ_CARRYIN_EN
      rc = 1'($urandom_range(0, 1));
`else
      rc = 1'b0;
`endif
      ref_sum = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_check(ra, rb, rc, ref_sum[W-1:0], ref_sum[W], 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
